grant_bus_mux: RTL

Downstream stage of the 4-master configurable arbiter. It samples the arbiter's one-hot `gnt` and latches the owning master's address, write data and write-enable. It then runs a valid/ready transfer on the single shared slave port and returns read data plus a per-master done pulse. Ownership stays locked for the whole transfer regardless of later `gnt` changes.

---
 rtl/grant_bus_mux_if.sv | 34 +++
 rtl/grant_bus_mux.sv | 133 +++++++++++++
 2 files changed

// File: rtl/grant_bus_mux_if.sv
// Bus bundle between the 4-master arbiter side, the grant mux and the shared slave port.
// Handshake: a transfer completes in the cycle where s_valid and s_ready are both high.
interface grant_bus_mux_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [3:0]          gnt;
    logic [4*ADDR_W-1:0] m_addr;
    logic [4*DATA_W-1:0] m_wdata;
    logic [3:0]          m_we;
    logic [3:0]          m_done;
    logic                m_err;
    logic [DATA_W-1:0]   m_rdata;
    logic                s_valid;
    logic [ADDR_W-1:0]   s_addr;
    logic [DATA_W-1:0]   s_wdata;
    logic                s_we;
    logic                s_ready;
    logic [DATA_W-1:0]   s_rdata;
    logic                busy;
    logic                multi_gnt;

    // Mux-side view.
    modport slave (
        input  gnt, m_addr, m_wdata, m_we, s_ready, s_rdata,
        output m_done, m_err, m_rdata, s_valid, s_addr, s_wdata, s_we, busy, multi_gnt
    );

    // Environment view: masters, arbiter and the shared slave.
    modport master (
        output gnt, m_addr, m_wdata, m_we, s_ready, s_rdata,
        input  m_done, m_err, m_rdata, s_valid, s_addr, s_wdata, s_we, busy, multi_gnt
    );
endinterface

// File: rtl/grant_bus_mux.sv
// Latches the granted master's request and runs one valid/ready transfer on the shared slave.
// Optional slave-wait timeout: define GRANT_BUS_MUX_TIMEOUT_EN.
module grant_bus_mux #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int TO_CYC = 15
) (
    input logic             clk,
    input logic             rst_n,
    grant_bus_mux_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (TO_CYC < 1) begin : g_bad_to_cyc
        $error("TO_CYC must be at least 1");
    end

    logic [1:0]        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              multi_q, multi_d;
    logic [1:0]        first_idx;
    logic              gnt_multi;

`ifdef GRANT_BUS_MUX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TO_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // Descending scan so the lowest set grant bit wins.
    always_comb begin
        first_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.gnt[i]) first_idx = 2'(i);
        end
        gnt_multi = (bus.gnt & (bus.gnt - 4'd1)) != 4'd0;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        multi_d = multi_q;
`ifdef GRANT_BUS_MUX_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.gnt != 4'd0) begin
                    state_d = XFER;
                    owner_d = first_idx;
                    addr_d  = bus.m_addr[first_idx*ADDR_W +: ADDR_W];
                    wdata_d = bus.m_wdata[first_idx*DATA_W +: DATA_W];
                    we_d    = bus.m_we[first_idx];
                    if (gnt_multi) multi_d = 1'b1;
`ifdef GRANT_BUS_MUX_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            XFER: begin
                if (bus.s_ready) begin
                    rdata_d = bus.s_rdata;
                    state_d = DONE;
`ifdef GRANT_BUS_MUX_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TO_CYC - 1)) begin
                    // Final allowed wait cycle passed without s_ready: abort.
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            multi_q <= 1'b0;
`ifdef GRANT_BUS_MUX_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            multi_q <= multi_d;
`ifdef GRANT_BUS_MUX_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Status outputs decode the registered state so reset clears them asynchronously.
    assign bus.s_valid   = (state_q == XFER);
    assign bus.busy      = (state_q != IDLE);
    assign bus.m_done    = (state_q == DONE) ? (4'b0001 << owner_q) : 4'b0000;
    assign bus.s_addr    = addr_q;
    assign bus.s_wdata   = wdata_q;
    assign bus.s_we      = we_q;
    assign bus.m_rdata   = rdata_q;
    assign bus.multi_gnt = multi_q;
`ifdef GRANT_BUS_MUX_TIMEOUT_EN
    assign bus.m_err     = err_q;
`else
    assign bus.m_err     = 1'b0;
`endif
endmodule
